// File: rtl/btn_pkg.sv
// btn_pkg
// Shared definitions for the multi-channel button debouncer.
// Contents:
//   press_state_t  per-channel press FSM encoding (REL, HELD, LONG)
//   tick_div()     clock cycles per sample tick
//   params_ok()    elaboration-time sanity check of the timing parameters
package btn_pkg;

  typedef enum logic [1:0] {
    REL  = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } press_state_t;

  // A zero tick rate is rejected by params_ok(); returning 1 here keeps
  // elaboration from dividing by zero before that check gets to report it.
  function automatic int tick_div(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0) return 1;
    return clk_hz / tick_hz;
  endfunction

  function automatic bit params_ok(input int clk_hz, input int tick_hz,
                                   input int deb_ticks, input int long_ticks,
                                   input int rep_ticks);
    if (tick_hz <= 0 || clk_hz < tick_hz) return 1'b0;
    if ((clk_hz % tick_hz) != 0) return 1'b0;
    if (deb_ticks < 1) return 1'b0;
    if (long_ticks <= deb_ticks) return 1'b0;
    if (rep_ticks < 1) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch
// One button channel: 2-FF synchroniser, tick-based stability filter and
// press FSM producing press/release/long/repeat pulses.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   tick            one-cycle sample strobe shared by all channels
//   btn             raw asynchronous button input, active-high
//   level           debounced level
//   press_pulse     one-cycle pulse on debounced 0->1
//   release_pulse   one-cycle pulse on debounced 1->0
//   long_pulse      one-cycle pulse when the hold reaches LONG_TICKS
//   repeat_pulse    one-cycle pulse every REP_TICKS while in the long hold
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEB_TICKS  = 10,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200,
  parameter bit REP_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REP_TICKS + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_TICKS - 1);

  logic          sync_a;
  logic          sample;
  logic [DW-1:0] deb_cnt;
  logic          flip;
  logic          rise;
  logic          fall;

  press_state_t  state;
  press_state_t  state_next;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_next;
  logic          long_next;
  logic          repeat_next;

  // The level flips only on the tick that completes DEB_TICKS consecutive
  // differing samples; rise/fall are that same instant seen combinationally,
  // so the FSM and the edge pulses move in the same clock as the level.
  assign flip = tick && (sample != level) && (deb_cnt == DEB_LAST);
  assign rise = flip && sample;
  assign fall = flip && !sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a        <= 1'b0;
      sample        <= 1'b0;
      level         <= 1'b0;
      deb_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_a        <= btn;
      sample        <= sync_a;
      press_pulse   <= rise;
      release_pulse <= fall;
      if (sample == level) begin
        deb_cnt <= '0;
      end else if (tick) begin
        if (deb_cnt == DEB_LAST) begin
          level   <= sample;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= REL;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_next;
      hold_cnt     <= hold_next;
      rep_cnt      <= rep_next;
      long_pulse   <= long_next;
      repeat_pulse <= repeat_next;
    end
  end

  // A debounced release is checked before the tick work in HELD and LONG,
  // so a release landing on the same tick as a long/repeat suppresses it.
  // hold_cnt parks at LONG_TICKS once the long pulse has fired.
  always_comb begin
    state_next  = state;
    hold_next   = hold_cnt;
    rep_next    = rep_cnt;
    long_next   = 1'b0;
    repeat_next = 1'b0;
    case (state)
      REL: begin
        if (rise) begin
          state_next = HELD;
          hold_next  = '0;
          rep_next   = '0;
        end
      end
      HELD: begin
        if (fall) begin
          state_next = REL;
          hold_next  = '0;
          rep_next   = '0;
        end else if (tick) begin
          hold_next = hold_cnt + HW'(1);
          if (hold_cnt == HOLD_LAST) begin
            long_next  = 1'b1;
            state_next = LONG;
            rep_next   = '0;
          end
        end
      end
      LONG: begin
        if (fall) begin
          state_next = REL;
          hold_next  = '0;
          rep_next   = '0;
        end else if (tick && REP_EN) begin
          if (rep_cnt == REP_LAST) begin
            repeat_next = 1'b1;
            rep_next    = '0;
          end else begin
            rep_next = rep_cnt + RW'(1);
          end
        end
      end
      default: begin
        state_next = REL;
        hold_next  = '0;
        rep_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi
// N-channel push-button debouncer and event generator. One shared sample
// tick drives N independent channels (sync, filter, press FSM).
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   i_btn      raw asynchronous button inputs, active-high
//   o_level    debounced levels
//   o_press    one-cycle pulse per channel on debounced 0->1
//   o_release  one-cycle pulse per channel on debounced 1->0
//   o_long     one-cycle pulse per channel when the hold reaches LONG_TICKS
//   o_repeat   one-cycle auto-repeat pulses after o_long (channels with REP_EN set)
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int               N_BTN      = 4,
  parameter int               CLK_HZ     = 100_000_000,
  parameter int               TICK_HZ    = 1_000,
  parameter int               DEB_TICKS  = 10,
  parameter int               LONG_TICKS = 1000,
  parameter int               REP_TICKS  = 200,
  parameter logic [N_BTN-1:0] REP_EN     = {N_BTN{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long,
  output logic [N_BTN-1:0] o_repeat
);

  localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int TW       = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  if (!params_ok(CLK_HZ, TICK_HZ, DEB_TICKS, LONG_TICKS, REP_TICKS)) begin : g_param_check
    $error("btn_debounce_multi: need CLK_HZ %% TICK_HZ == 0, DEB_TICKS >= 1, LONG_TICKS > DEB_TICKS, REP_TICKS >= 1");
  end

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running divider; restarts from zero on reset so all channels share
  // one well-defined tick phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEB_TICKS  (DEB_TICKS),
      .LONG_TICKS (LONG_TICKS),
      .REP_TICKS  (REP_TICKS),
      .REP_EN     (REP_EN[g])
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .btn           (i_btn[g]),
      .level         (o_level[g]),
      .press_pulse   (o_press[g]),
      .release_pulse (o_release[g]),
      .long_pulse    (o_long[g]),
      .repeat_pulse  (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi
// Self-checking bench for btn_debounce_multi with a 10-clk tick,
// DEB_TICKS=3, LONG_TICKS=10, REP_TICKS=4. A second instance has
// auto-repeat disabled on channel 0.
module tb_btn_debounce_multi;

  logic       clk;
  logic       rst;
  logic [3:0] i_btn;
  logic [3:0] o_level, o_press, o_release, o_long, o_repeat;
  logic [3:0] b_level, b_press, b_release, b_long, b_repeat;

  btn_debounce_multi #(
    .N_BTN(4), .CLK_HZ(1000), .TICK_HZ(100), .DEB_TICKS(3),
    .LONG_TICKS(10), .REP_TICKS(4), .REP_EN(4'b1111)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn), .o_level(o_level), .o_press(o_press),
    .o_release(o_release), .o_long(o_long), .o_repeat(o_repeat)
  );

  btn_debounce_multi #(
    .N_BTN(4), .CLK_HZ(1000), .TICK_HZ(100), .DEB_TICKS(3),
    .LONG_TICKS(10), .REP_TICKS(4), .REP_EN(4'b1110)
  ) dut_norep (
    .clk(clk), .rst(rst), .i_btn(i_btn), .o_level(b_level), .o_press(b_press),
    .o_release(b_release), .o_long(b_long), .o_repeat(b_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] btn;
    logic [3:0] exp_level;
    logic [3:0] exp_press;
    logic [3:0] exp_rel;
  } vec_t;

  vec_t vecs[7];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rst_cyc;

  int n_press[4], n_rel[4], n_long[4], n_rep[4];
  int t_press[4], t_rel[4], t_long[4], t_last_rep[4];
  int n_long2, n_rep2, t_long2;
  logic [3:0] first_press_vec, first_rel_vec;
  bit seen_press_vec, seen_rel_vec;

  task automatic check_eq(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic clear_counts();
    for (int ch = 0; ch < 4; ch++) begin
      n_press[ch] = 0; n_rel[ch] = 0; n_long[ch] = 0; n_rep[ch] = 0;
      t_press[ch] = -1; t_rel[ch] = -1; t_long[ch] = -1; t_last_rep[ch] = -1;
    end
    n_long2 = 0; n_rep2 = 0; t_long2 = -1;
    first_press_vec = '0; first_rel_vec = '0;
    seen_press_vec = 1'b0; seen_rel_vec = 1'b0;
  endtask

  // One clock: sample #1 after the rising edge and log every pulse.
  task automatic step();
    int prev;
    @(posedge clk);
    #1;
    cyc++;
    if (o_press != 4'b0 && !seen_press_vec) begin
      first_press_vec = o_press; seen_press_vec = 1'b1;
    end
    if (o_release != 4'b0 && !seen_rel_vec) begin
      first_rel_vec = o_release; seen_rel_vec = 1'b1;
    end
    for (int ch = 0; ch < 4; ch++) begin
      if (o_press[ch]) begin
        n_press[ch]++;
        if (t_press[ch] < 0) t_press[ch] = cyc;
      end
      if (o_release[ch]) begin
        n_rel[ch]++;
        if (t_rel[ch] < 0) t_rel[ch] = cyc;
      end
      if (o_long[ch]) begin
        n_long[ch]++;
        if (t_long[ch] < 0) t_long[ch] = cyc;
      end
      if (o_repeat[ch]) begin
        n_rep[ch]++;
        prev = (t_last_rep[ch] >= 0) ? t_last_rep[ch] : t_long[ch];
        if (prev >= 0) check_eq($sformatf("rep_spacing_ch%0d", ch), cyc - prev, 40);
        t_last_rep[ch] = cyc;
      end
    end
    if (b_long[0]) begin
      n_long2++;
      if (t_long2 < 0) t_long2 = cyc;
    end
    if (b_repeat[0]) n_rep2++;
  endtask

  task automatic apply_stimulus(input logic [3:0] btn, input int ncyc);
    i_btn = btn;
    for (int i = 0; i < ncyc; i++) step();
  endtask

  task automatic check_output(input vec_t v);
    check_eq({v.name, "_level"}, o_level, v.exp_level);
    for (int ch = 0; ch < 4; ch++) begin
      check_eq($sformatf("%s_press_ch%0d", v.name, ch), n_press[ch], v.exp_press[ch]);
      check_eq($sformatf("%s_rel_ch%0d", v.name, ch), n_rel[ch], v.exp_rel[ch]);
    end
    if (v.exp_press != 4'b0) check_eq({v.name, "_press_vec"}, first_press_vec, v.exp_press);
    if (v.exp_rel != 4'b0) check_eq({v.name, "_rel_vec"}, first_rel_vec, v.exp_rel);
    check_eq({v.name, "_long_any"}, n_long[0] + n_long[1] + n_long[2] + n_long[3], 0);
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "_dut"}, {o_level, o_press, o_release, o_long, o_repeat}, 0);
    check_eq({name, "_norep"}, {b_level, b_press, b_release, b_long, b_repeat}, 0);
  endtask

  initial begin
    int edge_cyc;
    int exp_rep;

    vecs[0] = '{"all_press",   4'b1111, 4'b1111, 4'b1111, 4'b0000};
    vecs[1] = '{"rel_ch3",     4'b0111, 4'b0111, 4'b0000, 4'b1000};
    vecs[2] = '{"rel_rest",    4'b0000, 4'b0000, 4'b0000, 4'b0111};
    vecs[3] = '{"press_ch12",  4'b0110, 4'b0110, 4'b0110, 4'b0000};
    vecs[4] = '{"rel_ch1",     4'b0100, 4'b0100, 4'b0000, 4'b0010};
    vecs[5] = '{"swap_03_2",   4'b1001, 4'b1001, 4'b1001, 4'b0100};
    vecs[6] = '{"all_rel",     4'b0000, 4'b0000, 4'b0000, 4'b1001};

    rst   = 1'b1;
    i_btn = 4'b0000;
    clear_counts();
    for (int i = 0; i < 3; i++) step();
    check_all_zero("reset_state");
    rst     = 1'b0;
    rst_cyc = cyc;

    // Clean press on channel 0, held 200 clk for long + repeat.
    $display("[TB] clean press, long press and auto-repeat on channel 0");
    clear_counts();
    edge_cyc = cyc;
    apply_stimulus(4'b0001, 40);
    check_eq("t1_press_count", n_press[0], 1);
    check_range("t1_press_latency", t_press[0] - edge_cyc, 22, 32);
    check_eq("t1_level", o_level, 4'b0001);
    apply_stimulus(4'b0001, 160);
    check_eq("t4_long_count", n_long[0], 1);
    check_eq("t4_long_delay", t_long[0] - t_press[0], 100);
    check_eq("t4_norep_long_count", n_long2, 1);
    check_eq("t4_norep_long_delay", t_long2 - t_press[0], 100);
    apply_stimulus(4'b0000, 160);
    check_eq("t4_release_count", n_rel[0], 1);
    check_eq("t4_release_delay", t_rel[0] - t_press[0], 200);
    exp_rep = 0;
    if (t_long[0] >= 0 && t_rel[0] >= 0)
      for (int t = t_long[0] + 40; t < t_rel[0]; t += 40) exp_rep++;
    check_eq("t4_repeat_count", n_rep[0], exp_rep);
    check_eq("t4_repeat_min", (n_rep[0] >= 1) ? 1 : 0, 1);
    check_eq("t4_norep_repeat_count", n_rep2, 0);
    check_eq("t4_level_after", o_level, 4'b0000);
    check_eq("t1_idle_channels",
             n_press[1] + n_press[2] + n_press[3] + n_rel[1] + n_rel[2] + n_rel[3] +
             n_long[1] + n_long[2] + n_long[3] + n_rep[1] + n_rep[2] + n_rep[3], 0);

    // Bounce on channel 1: toggles every 5 clk never survive 3 ticks.
    $display("[TB] bounce on channel 1");
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      i_btn[1] = ~i_btn[1];
      for (int k = 0; k < 5; k++) step();
    end
    check_eq("t2_bounce_press", n_press[1], 0);
    check_eq("t2_bounce_level", o_level[1], 1'b0);
    i_btn[1] = 1'b1;
    edge_cyc = cyc;
    for (int k = 0; k < 40; k++) step();
    check_eq("t2_press_count", n_press[1], 1);
    check_range("t2_press_latency", t_press[1] - edge_cyc, 22, 32);
    check_eq("t2_spurious_release", n_rel[1], 0);
    apply_stimulus(4'b0000, 40);
    check_eq("t2_release_count", n_rel[1], 1);

    // Glitch on channel 2: 25 clk high placed so that only two ticks see it.
    $display("[TB] glitch on channel 2");
    for (int i = 0; i < 10 && ((cyc - rst_cyc) % 10) != 2; i++) step();
    clear_counts();
    apply_stimulus(4'b0100, 25);
    apply_stimulus(4'b0000, 40);
    check_eq("t3_glitch_level", o_level[2], 1'b0);
    check_eq("t3_glitch_pulses", n_press[2] + n_rel[2] + n_long[2] + n_rep[2], 0);

    // Table of multi-channel press/release patterns.
    $display("[TB] multi-channel pattern table");
    for (int v = 0; v < 7; v++) begin
      clear_counts();
      apply_stimulus(vecs[v].btn, 40);
      check_output(vecs[v]);
    end

    // Reset while channel 0 sits in the long hold with the button still down.
    $display("[TB] reset during long hold");
    clear_counts();
    i_btn = 4'b0001;
    for (int i = 0; i < 200 && n_long[0] == 0; i++) step();
    check_eq("t6_reached_long", n_long[0], 1);
    rst = 1'b1;
    step();
    check_all_zero("t6_reset_outputs");
    rst     = 1'b0;
    rst_cyc = cyc;
    clear_counts();
    apply_stimulus(4'b0001, 150);
    check_eq("t6_press_count", n_press[0], 1);
    check_range("t6_press_latency", t_press[0] - rst_cyc, 22, 32);
    check_eq("t6_long_count", n_long[0], 1);
    check_eq("t6_long_delay", t_long[0] - t_press[0], 100);
    check_eq("t6_other_press", n_press[1] + n_press[2] + n_press[3], 0);
    apply_stimulus(4'b0000, 40);
    check_eq("t6_release_count", n_rel[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
